alu_reg_file: RTL and testbench
===============================

// Module: alu_reg_file
// PURPOSE
//  Register file that sits directly around the 16-bit ALU. It sources the ALU's
//  Data_A/Data_B operands and sinks its ALU_out result and Zero flag.
//  - Two registered read ports feed the ALU; one write port takes the ALU result
//    back at writeback.
//  - A flag register holds Zero for the branch logic in the controller.
//  - R0 is hardwired to zero.
// PARAMETERS
//  DATA_W    16  register/operand width; matches ALU datapath
//  ADDR_W    3   register address width
//  NUM_REGS  8   number of registers (2**ADDR_W); R0 is constant 0
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst_n      in   1       synchronous, active-low reset
//  rd_en      in   1       capture both read ports this cycle
//  rd_addr_a  in   ADDR_W  source register for Data_A
//  rd_addr_b  in   ADDR_W  source register for Data_B
//  Data_A     out  DATA_W  registered operand A to ALU
//  Data_B     out  DATA_W  registered operand B to ALU
//  rd_valid   out  1       Data_A/Data_B updated by the previous cycle's rd_en
//  wr_en      in   1       write wr_data into wr_addr
//  wr_addr    in   ADDR_W  destination register
//  wr_data    in   DATA_W  result from ALU_out
//  zero_we    in   1       load zero_in into zero_flag
//  zero_in    in   1       Zero output from ALU
//  zero_flag  out  1       latched Zero flag
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): R1..R7=0, Data_A=Data_B=0, rd_valid=0, zero_flag=0.
//    Reset overrides rd_en/wr_en/zero_we in the same cycle. Reset mid-read or
//    mid-write discards that operation.
//  - Read latency 1 cycle: rd_en at edge N -> Data_A=R[rd_addr_a] and
//    Data_B=R[rd_addr_b] from edge N; rd_valid=1 for that one cycle.
//    rd_en=0 -> Data_A/Data_B hold; rd_valid=0.
//  - Address 0 always reads 0. Both ports may read the same address.
//  - Write: wr_en at edge -> R[wr_addr]=wr_data. wr_addr=0 is silently ignored.
//    Full DATA_W stored, no truncation or sign extension.
//  - Same-cycle read and write of the same nonzero address: see CONFIGURATION.
//  - zero_flag: zero_we at edge -> zero_flag=zero_in; otherwise hold.
//    zero_flag is independent of wr_en.
//  - Writing all NUM_REGS then reading back wraps nothing; addresses are exact,
//    with no aliasing.
// CONFIGURATION
//  ALU_RF_WRITE_BYPASS_EN
//   defined: read of the address being written in the same cycle returns wr_data
//     (write-first). Applies per port independently; never applies to address 0.
//   undefined: such a read returns the old register contents (read-first). The
//     new value is visible on the next rd_en.
// STRUCTURE
//  - Shared package alu_pkg:
//    - DATA_W, ADDR_W, NUM_REGS
//    - op_sel encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_INC=2'b10, ALU_XOR=2'b11
//    - register index constant REG_ZERO=0
//  - Sub-module alu_rf_read_port: address decode, R0 masking, bypass mux, and
//    output register. Instantiated twice (A, B).
//  - Storage array and write logic live in the top.
// TESTING
//  1 Reset: write R3=16'h1234, then assert rst_n=0 for 1 cycle, then read R3
//    -> Data_A=16'h0000, zero_flag=0, rd_valid=0 during reset.
//  2 Basic R/W: write R1=16'hFFFF, R2=16'h0001; rd_en with A=1, B=2
//    -> next cycle Data_A=FFFF, Data_B=0001, rd_valid=1. ALU ADD result 0000
//    written to R4 reads back 0000.
//  3 R0: wr_en, wr_addr=0, wr_data=16'hBEEF; then read A=0, B=0
//    -> Data_A=Data_B=0.
//  4 Collision: R5=16'h00AA; same cycle wr R5=16'h0055 and rd A=5
//    -> Data_A=0055 with ALU_RF_WRITE_BYPASS_EN, 00AA without it.
//  5 Flag: zero_we with zero_in=1 -> zero_flag=1; 3 idle cycles -> stays 1;
//    zero_we with zero_in=0 -> 0. Also wr_en alone -> flag unchanged.
//  6 Hold: rd_en=0 for 4 cycles while writing the read addresses
//    -> Data_A/B unchanged, rd_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and encodings for the 16-bit ALU and its register file.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_INC = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    localparam reg_addr_t REG_ZERO  = {ADDR_W{1'b0}};
    localparam word_t     WORD_ZERO = {DATA_W{1'b0}};

endpackage

// File: rtl/alu_rf_read_port.sv
// One registered read port: R0 masking, optional write-first bypass, output register.
// Optional feature: ALU_RF_WRITE_BYPASS_EN selects write-first on same-address collision.
module alu_rf_read_port
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_rd_en,
    input  reg_addr_t i_rd_addr,
    input  word_t     i_regs [NUM_REGS],
    input  logic      i_wr_en,
    input  reg_addr_t i_wr_addr,
    input  word_t     i_wr_data,
    output word_t     o_data
);

    word_t w_data;
    word_t r_data;

    // Select the value to capture; R0 always wins over any bypass.
    always_comb begin
        w_data = WORD_ZERO;
        if (i_rd_addr == REG_ZERO) begin
            w_data = WORD_ZERO;
`ifdef ALU_RF_WRITE_BYPASS_EN
        end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            w_data = i_wr_data;
`endif
        end else begin
            w_data = i_regs[i_rd_addr];
        end
    end

`ifndef ALU_RF_WRITE_BYPASS_EN
    logic w_unused_bypass;
    assign w_unused_bypass = i_wr_en ^ (^i_wr_addr) ^ (^i_wr_data);
`endif

    // Operand register: loads on rd_en, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= WORD_ZERO;
        end else if (i_rd_en) begin
            r_data <= w_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/alu_reg_file.sv
// Register file around the 16-bit ALU: two registered read ports, one write port, Zero flag.
// Optional feature: ALU_RF_WRITE_BYPASS_EN (write-first collision handling in the read ports).
module alu_reg_file
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] Data_A,
    output logic [DATA_W-1:0] Data_B,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              zero_we,
    input  logic              zero_in,
    output logic              zero_flag
);

    word_t r_regs [NUM_REGS];
    logic  r_rd_valid;
    logic  r_zero_flag;

    // Storage array; R0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= WORD_ZERO;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            r_regs[wr_addr] <= wr_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Read strobe and Zero flag for the controller.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_rd_valid  <= rd_en;
            r_zero_flag <= zero_we ? zero_in : r_zero_flag;
        end
    end

    alu_rf_read_port u_port_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr_a),
        .i_regs    (r_regs),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_data    (Data_A)
    );

    alu_rf_read_port u_port_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr_b),
        .i_regs    (r_regs),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_data    (Data_B)
    );

    assign rd_valid  = r_rd_valid;
    assign zero_flag = r_zero_flag;

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed, table-driven bench for alu_reg_file; honours ALU_RF_WRITE_BYPASS_EN for collisions.
module tb_alu_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] Data_A, Data_B;
    logic        rd_valid;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        zero_we, zero_in;
    logic        zero_flag;

    int checks   = 0;
    int failures = 0;

    alu_reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .Data_A    (Data_A),
        .Data_B    (Data_B),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .zero_we   (zero_we),
        .zero_in   (zero_in),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic        rd_en;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        zero_we;
        logic        zero_in;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_v;
        logic        exp_z;
    } vec_t;

    vec_t vecs [14];

`ifdef ALU_RF_WRITE_BYPASS_EN
    localparam logic [15:0] COLL_EXP = 16'h0055;
`else
    localparam logic [15:0] COLL_EXP = 16'h00AA;
`endif

    // Drive one cycle of inputs, clock it, then compare all outputs.
    task automatic step(input vec_t v, input string name);
        rst_n     = v.rst_n;
        wr_en     = v.wr_en;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        rd_en     = v.rd_en;
        rd_addr_a = v.ra;
        rd_addr_b = v.rb;
        zero_we   = v.zero_we;
        zero_in   = v.zero_in;
        @(posedge clk);
        #1;
        checks++;
        if (Data_A !== v.exp_a || Data_B !== v.exp_b || rd_valid !== v.exp_v || zero_flag !== v.exp_z) begin
            failures++;
            $display("FAIL %s: got A=%h B=%h v=%b z=%b, expected A=%h B=%h v=%b z=%b",
                     name, Data_A, Data_B, rd_valid, zero_flag, v.exp_a, v.exp_b, v.exp_v, v.exp_z);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic re, input logic [2:0] ra, input logic [2:0] rb,
                                input logic zw, input logic zi,
                                input logic [15:0] ea, input logic [15:0] eb, input logic ev, input logic ez);
        vec_t v;
        v.rst_n = rs; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.rd_en = re; v.ra = ra; v.rb = rb; v.zero_we = zw; v.zero_in = zi;
        v.exp_a = ea; v.exp_b = eb; v.exp_v = ev; v.exp_z = ez;
        return v;
    endfunction

    initial begin
        // Main sequence: basic write/read, ALU result writeback, R0, same-address reads.
        vecs[0]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 3'd4, 16'h0000, 1'b1, 3'd4, 3'd1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 3'd7, 16'hA5A5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 3'd6, 16'h8001, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        vecs[10] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd7, 1'b0, 1'b0, 16'h8001, 16'hA5A5, 1'b1, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd7, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1);
        // R0 collision: bypass never applies to address 0.
        vecs[12] = mk(1'b1, 1'b1, 3'd0, 16'hBEEF, 1'b1, 3'd0, 3'd6, 1'b1, 1'b0, 16'h0000, 16'h8001, 1'b1, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h8001, 1'b0, 1'b0);

        step(vecs[0], "reset_init");
        for (int i = 1; i < 14; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Exact addressing: distinct values in R1..R7, read back crosswise.
        for (int i = 1; i < 8; i++) begin
            step(mk(1'b1, 1'b1, 3'(i), 16'(i * 16'h1111), 1'b0, 3'd0, 3'd0, 1'b0, 1'b0,
                    16'h0000, 16'h8001, 1'b0, 1'b0), $sformatf("fill%0d", i));
        end
        for (int i = 1; i < 8; i++) begin
            step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 3'(8 - i), 1'b0, 1'b0,
                    16'(i * 16'h1111), 16'((8 - i) * 16'h1111), 1'b1, 1'b0), $sformatf("alias%0d", i));
        end

        // Collision: R5=00AA, then write 0055 while both ports read R5.
        step(mk(1'b1, 1'b1, 3'd5, 16'h00AA, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h7777, 16'h1111, 1'b0, 1'b0), "coll_pre");
        step(mk(1'b1, 1'b1, 3'd5, 16'h0055, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, COLL_EXP, COLL_EXP, 1'b1, 1'b0), "collision");
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 1'b0, 1'b0, 16'h0055, 16'h3333, 1'b1, 1'b0), "coll_after");

        // Flag: set, hold through idle cycles and a bare write, clear, ignore zero_in without zero_we.
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0055, 16'h3333, 1'b0, 1'b1), "flag_set");
        for (int i = 0; i < 3; i++) begin
            step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0055, 16'h3333, 1'b0, 1'b1), "flag_hold");
        end
        step(mk(1'b1, 1'b1, 3'd2, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0055, 16'h3333, 1'b0, 1'b1), "flag_wr_only");
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 16'h0055, 16'h3333, 1'b0, 1'b0), "flag_clr");
        step(mk(1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0055, 16'h3333, 1'b0, 1'b0), "flag_no_we");

        // Hold: capture R1/R2, then overwrite them for 4 cycles with rd_en low.
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 16'h1111, 16'h0001, 1'b1, 1'b0), "hold_cap");
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b1, 1'b1, 3'(1 + (i % 2)), 16'(16'hC000 + i), 1'b0, 3'd1, 3'd2, 1'b0, 1'b0,
                    16'h1111, 16'h0001, 1'b0, 1'b0), $sformatf("hold%0d", i));
        end
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 16'hC002, 16'hC003, 1'b1, 1'b0), "hold_new");

        // Reset: R3=1234 and flag set, then reset while reading R3 and writing it.
        step(mk(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 16'hC002, 16'hC002, 1'b1, 1'b1), "rst_pre");
        step(mk(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b1, 3'd3, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0), "rst_active");
        step(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd7, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0), "rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
